// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX-side arbitration blocks.
package uart_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the closest hit to ptr wins last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ]) begin
        valid = 1'b1;
        index = IDX_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources, with a
// watchdog on the transmitter's frame-complete pulse. All outputs are registered.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           tx_data_in,
  output logic                        start,
  input  logic                        tx_active,
  input  logic                        done_tx,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [CNT_W-1:0]            frames_sent
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [DATA_W-1:0]  data_n;
  logic [IDX_W-1:0]   owner_n;
  logic               start_n, busy_n, err_n;
  logic [CNT_W-1:0]   frames_n;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Transmitter busy is status only; sequencing relies on done_tx alone.
  logic unused_status;
  assign unused_status = tx_active;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      wd          <= '0;
      gnt         <= '0;
      tx_data_in  <= '0;
      owner       <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      wd          <= wd_n;
      gnt         <= gnt_n;
      tx_data_in  <= data_n;
      owner       <= owner_n;
      start       <= start_n;
      busy        <= busy_n;
      err_timeout <= err_n;
      frames_sent <= frames_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    wd_n     = wd;
    gnt_n    = '0;
    data_n   = tx_data_in;
    owner_n  = owner;
    start_n  = 1'b0;
    err_n    = 1'b0;
    frames_n = frames_sent;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_n[pick_idx] = 1'b1;
          data_n          = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          owner_n         = pick_idx;
          ptr_n           = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_n         = LAUNCH;
        end
      end
      LAUNCH: begin
        start_n = 1'b1;
        wd_n    = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A completion in the same cycle as the watchdog expiry wins.
        if (done_tx) begin
          frames_n = frames_sent + 1'b1;
          state_n  = GAP;
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          err_n   = 1'b1;
          state_n = GAP;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
